// File: rtl/rv32i_gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_gcd_pkg
//  Purpose  : Shared definitions for the RV32I GCD offload controller:
//             controller state encoding, the register-file slots used for
//             the software handshake with the core, and the length of the
//             core reset pulse.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_gcd_pkg;

  // Controller states, encoded explicitly on 2 bits.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } gcd_state_e;

  // Register-file slots of the GCD program running on the core.
  localparam logic [4:0] GCD_RESULT_REG = 5'd10;  // a0: result written here
  localparam logic [4:0] GCD_A_REG      = 5'd28;  // t3: operand A
  localparam logic [4:0] GCD_B_REG      = 5'd29;  // t4: operand B
  localparam logic [4:0] GCD_START_REG  = 5'd31;  // t6: start flag

  // Number of cycles the core is held in reset before each calculation.
  localparam int LAUNCH_CYCLES = 2;

endpackage : rv32i_gcd_pkg
`default_nettype wire

// File: rtl/rv32i_gcd_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_gcd_timeout_cnt
//  Purpose  : Cycle budget counter for the RUN phase. Counts enabled cycles
//             from zero and flags expiry when the count reaches
//             TIMEOUT_CYCLES-1. The count saturates there and never wraps.
//  Ports    : clk     - clock, rising edge
//             rst_n   - asynchronous active-low reset
//             clear   - synchronous clear (has priority over enable)
//             enable  - advance the count by one
//             expired - count equals TIMEOUT_CYCLES-1
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_gcd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            c_CNT_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST_COUNT = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      // Holding at the last value keeps expired asserted instead of wrapping.
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == c_LAST_COUNT);

endmodule : rv32i_gcd_timeout_cnt
`default_nettype wire

// File: rtl/rv32i_gcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_gcd_ctrl
//  Purpose  : Wraps an RV32I core running a GCD program as a request/response
//             accelerator. On an accepted request the operands are presented
//             to the core's register file, the core is pulsed through reset,
//             and the controller then watches register-file writes for the
//             result. A trivial request (either operand zero) is answered
//             without touching the core. A cycle budget aborts a hung core.
//  Ports    : clk, rst_n                 - clock / async active-low reset
//             req_valid/req_ready/req_a/req_b
//                                         - operand request handshake
//             resp_valid/resp_ready/resp_result/resp_timeout
//                                         - result handshake
//             core_rst_n                  - reset to the CPU core
//             calc_start, gcd_a, gcd_b    - values forced into the regfile
//             wb_we, wb_addr, wb_data     - snoop of regfile writes
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_gcd_ctrl
  import rv32i_gcd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter logic [4:0] RESULT_REG     = GCD_RESULT_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_timeout,
  output logic        core_rst_n,
  output logic        calc_start,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  localparam int                 c_LCNT_W     = (LAUNCH_CYCLES > 1) ? $clog2(LAUNCH_CYCLES) : 1;
  localparam logic [c_LCNT_W-1:0] c_LAUNCH_LAST = c_LCNT_W'(LAUNCH_CYCLES - 1);
  // A result register of x0 can never be observed, so it disables capture.
  localparam logic               c_CAPTURE_EN = (RESULT_REG != 5'd0);

  gcd_state_e          r_state;
  gcd_state_e          w_next_state;
  logic [c_LCNT_W-1:0] r_launch_cnt;
  logic [31:0]         r_gcd_a;
  logic [31:0]         r_gcd_b;
  logic [31:0]         r_result;
  logic                r_timeout;
  logic                r_core_rst_n;

  logic w_accept;
  logic w_zero_op;
  logic w_wb_hit;
  logic w_expired;
  logic w_in_run;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_zero_op = (req_a == 32'd0) || (req_b == 32'd0);
  // Snooped writes only matter while the core is actually computing.
  assign w_wb_hit  = w_in_run && c_CAPTURE_EN && wb_we && (wb_addr == RESULT_REG);

  rv32i_gcd_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_in_run),
    .enable  (w_in_run),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_zero_op ? ST_RESP : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (r_launch_cnt == c_LAUNCH_LAST) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_wb_hit || w_expired) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_launch_cnt <= '0;
      r_gcd_a      <= '0;
      r_gcd_b      <= '0;
      r_result     <= '0;
      r_timeout    <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      // Registered from the next state so the core reset lines up exactly
      // with the LAUNCH cycles and releases one edge after rst_n rises.
      r_core_rst_n <= (w_next_state != ST_LAUNCH);

      if (w_accept) begin
        r_gcd_a      <= req_a;
        r_gcd_b      <= req_b;
        r_launch_cnt <= '0;
        if (w_zero_op) begin
          // gcd(0,x)=x; both zero falls out naturally as 0.
          r_result  <= (req_a == 32'd0) ? req_b : req_a;
          r_timeout <= 1'b0;
        end
      end

      if (r_state == ST_LAUNCH) begin
        r_launch_cnt <= r_launch_cnt + 1'b1;
      end

      if (w_in_run) begin
        // A result write in the expiry cycle wins over the timeout.
        if (w_wb_hit) begin
          r_result  <= wb_data;
          r_timeout <= 1'b0;
        end else if (w_expired) begin
          r_result  <= '0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all decoded from registered state only
  // --------------------------------------------------------------------------
  assign req_ready    = (r_state == ST_IDLE);
  assign resp_valid   = (r_state == ST_RESP);
  assign calc_start   = w_in_run;
  assign resp_result  = r_result;
  assign resp_timeout = r_timeout;
  assign core_rst_n   = r_core_rst_n;
  assign gcd_a        = r_gcd_a;
  assign gcd_b        = r_gcd_b;

endmodule : rv32i_gcd_ctrl
`default_nettype wire

// File: tb/tb_rv32i_gcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_gcd_ctrl
//  Purpose  : Self-checking bench for rv32i_gcd_ctrl. Two instances share
//             the stimulus: one with the default cycle budget and one with a
//             16-cycle budget for the timeout cases. A select bit chooses
//             which instance's outputs are checked.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_gcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_ready = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        sel = 1'b0;

  logic        d_req_ready, d_resp_valid, d_resp_timeout, d_core_rst_n, d_calc_start;
  logic [31:0] d_resp_result, d_gcd_a, d_gcd_b;
  logic        t_req_ready, t_resp_valid, t_resp_timeout, t_core_rst_n, t_calc_start;
  logic [31:0] t_resp_result, t_gcd_a, t_gcd_b;

  logic        m_req_ready, m_resp_valid, m_resp_timeout, m_core_rst_n, m_calc_start;
  logic [31:0] m_resp_result, m_gcd_a, m_gcd_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_gcd_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(d_req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(d_resp_valid), .resp_ready(resp_ready),
    .resp_result(d_resp_result), .resp_timeout(d_resp_timeout),
    .core_rst_n(d_core_rst_n), .calc_start(d_calc_start),
    .gcd_a(d_gcd_a), .gcd_b(d_gcd_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  rv32i_gcd_ctrl #(.TIMEOUT_CYCLES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(t_req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(t_resp_valid), .resp_ready(resp_ready),
    .resp_result(t_resp_result), .resp_timeout(t_resp_timeout),
    .core_rst_n(t_core_rst_n), .calc_start(t_calc_start),
    .gcd_a(t_gcd_a), .gcd_b(t_gcd_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  assign m_req_ready    = sel ? t_req_ready    : d_req_ready;
  assign m_resp_valid   = sel ? t_resp_valid   : d_resp_valid;
  assign m_resp_timeout = sel ? t_resp_timeout : d_resp_timeout;
  assign m_core_rst_n   = sel ? t_core_rst_n   : d_core_rst_n;
  assign m_calc_start   = sel ? t_calc_start   : d_calc_start;
  assign m_resp_result  = sel ? t_resp_result  : d_resp_result;
  assign m_gcd_a        = sel ? t_gcd_a        : d_gcd_a;
  assign m_gcd_b        = sel ? t_gcd_b        : d_gcd_b;

  typedef struct {
    logic        sel;        // 1: check the 16-cycle-budget instance
    logic [31:0] a;
    logic [31:0] b;
    int          wr_cyc;     // RUN cycle of the x10 write, -1 for none
    logic [31:0] wr_data;
    logic [31:0] exp_res;
    logic        exp_to;
    logic        exp_launch;
    int          exp_run;    // RUN cycles before RESP
    int          hold;       // cycles resp_ready stays low in RESP
    logic        spam;       // write x10=9 while waiting in RESP
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    wb_we      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
  endtask

  task automatic check_reset_vals();
    chkb("rst_req_ready",    m_req_ready,    1'b1);
    chkb("rst_resp_valid",   m_resp_valid,   1'b0);
    chk ("rst_resp_result",  m_resp_result,  32'd0);
    chkb("rst_resp_timeout", m_resp_timeout, 1'b0);
    chkb("rst_calc_start",   m_calc_start,   1'b0);
    chk ("rst_gcd_a",        m_gcd_a,        32'd0);
    chk ("rst_gcd_b",        m_gcd_b,        32'd0);
    chkb("rst_core_rst_n",   m_core_rst_n,   1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("post_rst_core_rst_n", m_core_rst_n, 1'b1);
    chkb("post_rst_req_ready",  m_req_ready,  1'b1);
  endtask

  // Starts at a negedge with the checked instance in IDLE; ends at a negedge
  // in IDLE after the response handshake.
  task automatic run_txn(input vec_t v);
    int k;
    chkb("idle_req_ready", m_req_ready, 1'b1);
    req_valid = 1'b1;
    req_a     = v.a;
    req_b     = v.b;
    @(negedge clk);                        // T+1
    req_valid = 1'b0;
    chk("gcd_a_latched", m_gcd_a, v.a);
    chk("gcd_b_latched", m_gcd_b, v.b);
    chkb("t1_calc_start", m_calc_start, 1'b0);
    if (v.exp_launch) begin
      chkb("t1_core_rst_n", m_core_rst_n, 1'b0);
      chkb("t1_resp_valid", m_resp_valid, 1'b0);
      // A result-register write during LAUNCH must be ignored.
      wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'hBAD0;
      @(negedge clk);                      // T+2
      chkb("t2_core_rst_n", m_core_rst_n, 1'b0);
      chkb("t2_calc_start", m_calc_start, 1'b0);
      @(negedge clk);                      // T+3, first RUN cycle
      wb_we = 1'b0;
      chkb("t3_core_rst_n", m_core_rst_n, 1'b1);
      chkb("t3_calc_start", m_calc_start, 1'b1);
      k = 0;
      while (!m_resp_valid && k < 200) begin
        if (k == v.wr_cyc) begin
          wb_we = 1'b1; wb_addr = 5'd10; wb_data = v.wr_data;
        end else if (k == 0) begin
          // Write to a neighbouring register must not be taken as the result.
          wb_we = 1'b1; wb_addr = 5'd11; wb_data = 32'hBAD1;
        end
        @(negedge clk);
        wb_we = 1'b0;
        k++;
      end
      chk("run_cycles", k, v.exp_run);
    end else begin
      chkb("t1_core_rst_n", m_core_rst_n, 1'b1);
    end
    chkb("resp_valid",   m_resp_valid,   1'b1);
    chk ("resp_result",  m_resp_result,  v.exp_res);
    chkb("resp_timeout", m_resp_timeout, v.exp_to);
    chkb("resp_core_rst_n", m_core_rst_n, 1'b1);
    chkb("resp_calc_start", m_calc_start, 1'b0);
    for (int h = 0; h < v.hold; h++) begin
      if (v.spam) begin
        wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'd9;
      end
      @(negedge clk);
      chkb("hold_resp_valid",   m_resp_valid,   1'b1);
      chk ("hold_resp_result",  m_resp_result,  v.exp_res);
      chkb("hold_resp_timeout", m_resp_timeout, v.exp_to);
      chkb("hold_req_ready",    m_req_ready,    1'b0);
    end
    wb_we = 1'b0;
    // Handshake cycle: a competing request must not be accepted.
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_a      = 32'h77;
    req_b      = 32'h55;
    chkb("hs_req_ready", m_req_ready, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chkb("after_hs_resp_valid", m_resp_valid, 1'b0);
    chkb("after_hs_req_ready",  m_req_ready,  1'b1);
    chk ("after_hs_gcd_a",      m_gcd_a,      v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t mv;
    vecs[0] = '{sel:1'b0, a:32'd48,  b:32'd18, wr_cyc:20, wr_data:32'd6,  exp_res:32'd6,
                exp_to:1'b0, exp_launch:1'b1, exp_run:21, hold:10, spam:1'b1};
    vecs[1] = '{sel:1'b0, a:32'd0,   b:32'd35, wr_cyc:-1, wr_data:32'd0,  exp_res:32'd35,
                exp_to:1'b0, exp_launch:1'b0, exp_run:0,  hold:2,  spam:1'b1};
    vecs[2] = '{sel:1'b0, a:32'd35,  b:32'd0,  wr_cyc:-1, wr_data:32'd0,  exp_res:32'd35,
                exp_to:1'b0, exp_launch:1'b0, exp_run:0,  hold:0,  spam:1'b0};
    vecs[3] = '{sel:1'b0, a:32'd0,   b:32'd0,  wr_cyc:-1, wr_data:32'd0,  exp_res:32'd0,
                exp_to:1'b0, exp_launch:1'b0, exp_run:0,  hold:1,  spam:1'b0};
    vecs[4] = '{sel:1'b0, a:32'd21,  b:32'd14, wr_cyc:2,  wr_data:32'd7,  exp_res:32'd7,
                exp_to:1'b0, exp_launch:1'b1, exp_run:3,  hold:0,  spam:1'b0};
    vecs[5] = '{sel:1'b1, a:32'd9,   b:32'd6,  wr_cyc:-1, wr_data:32'd0,  exp_res:32'd0,
                exp_to:1'b1, exp_launch:1'b1, exp_run:16, hold:3,  spam:1'b1};
    vecs[6] = '{sel:1'b1, a:32'd48,  b:32'd18, wr_cyc:15, wr_data:32'd7,  exp_res:32'd7,
                exp_to:1'b0, exp_launch:1'b1, exp_run:16, hold:0,  spam:1'b0};
    vecs[7] = '{sel:1'b1, a:32'd100, b:32'd75, wr_cyc:14, wr_data:32'd25, exp_res:32'd25,
                exp_to:1'b0, exp_launch:1'b1, exp_run:15, hold:1,  spam:1'b0};

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      do_reset();
      run_txn(vecs[i]);
    end

    // Back-to-back transaction without an intervening reset.
    sel = 1'b0;
    run_txn(vecs[4]);

    // Reset asserted in the middle of RUN aborts silently.
    sel = 1'b0;
    do_reset();
    req_valid = 1'b1;
    req_a     = 32'd48;
    req_b     = 32'd18;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chkb("midrun_calc_start", m_calc_start, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chkb("midrun_no_resp", m_resp_valid, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chkb("midrun_core_rst_n", m_core_rst_n, 1'b1);
    chkb("midrun_no_resp2",   m_resp_valid, 1'b0);
    mv = vecs[4];
    run_txn(mv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rv32i_gcd_ctrl
`default_nettype wire

// File: doc/rv32i_gcd_ctrl.md
RV32I_GCD_CTRL -- requirements
Module: rv32i_gcd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65536: RUN-state cycle budget before abort; legal range 2..2^24.
REQ-002 SHALL have parameter RESULT_REG, default 5'd10: register index whose write carries the GCD result.
REQ-003 SHALL have ports, one per line:
  clk  input  1  clock, all state on rising edge
  rst_n  input  1  reset, asynchronous, active-low
  req_valid  input  1  operand request valid
  req_ready  output  1  request accepted when high with req_valid
  req_a  input  32  operand A
  req_b  input  32  operand B
  resp_valid  output  1  result valid, held until resp_ready
  resp_ready  input  1  consumer accepts result
  resp_result  output  32  GCD result
  resp_timeout  output  1  result invalid, core did not finish
  core_rst_n  output  1  active-low reset to CPU core (regfile, PC)
  calc_start  output  1  drives regfile GCD start flag (x31)
  gcd_a  output  32  drives regfile operand A (x28)
  gcd_b  output  32  drives regfile operand B (x29)
  wb_we  input  1  snoop of regfile write enable
  wb_addr  input  5  snoop of regfile write address
  wb_data  input  32  snoop of regfile write data

Function
REQ-004 SHALL implement FSM with states IDLE, LAUNCH, RUN, RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE; accept on req_valid && req_ready (cycle T).
REQ-006 On accept, SHALL register req_a/req_b into gcd_a/gcd_b and hold them stable until the next accept.
REQ-007 On accept with req_a==0 or req_b==0, SHALL go directly to RESP at T+1 with resp_result = the other operand (0 if both 0), timeout=0, no core launch.
REQ-008 Otherwise, SHALL enter LAUNCH at T+1 and drive core_rst_n=0 for exactly 2 cycles (T+1, T+2).
REQ-009 SHALL enter RUN at T+3 with core_rst_n=1 and calc_start=1; calc_start=0 in all other states.
REQ-010 In RUN, SHALL capture wb_data when wb_we && wb_addr==RESULT_REG && RESULT_REG!=0, and enter RESP next cycle with resp_valid=1, resp_timeout=0.
REQ-011 SHALL ignore snooped writes in IDLE, LAUNCH and RESP.
REQ-012 SHALL count RUN cycles from 0; if count reaches TIMEOUT_CYCLES-1 with no result write, SHALL enter RESP with resp_result=0, resp_timeout=1.
REQ-013 On a result write in the same cycle as timeout expiry, SHALL give priority to the write (timeout=0).
REQ-014 In RESP, SHALL hold resp_valid, resp_result and resp_timeout stable until resp_ready; on handshake, SHALL return to IDLE next cycle, where resp_valid=0.
REQ-015 SHALL not accept a new request in the handshake cycle; earliest next accept is the cycle after.
REQ-016 SHALL keep core_rst_n=1 in IDLE and RESP, so the core spins polling calc_start=0.
REQ-017 Counter width SHALL be $clog2(TIMEOUT_CYCLES); SHALL clear on entry to RUN; no wrap.

Reset
REQ-018 On rst_n low, SHALL immediately force: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_timeout=0, calc_start=0, gcd_a=0, gcd_b=0, core_rst_n=0, counter=0.
REQ-019 core_rst_n SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-020 Reset mid-operation (any state) SHALL abort without emitting a response.

Structure
REQ-021 Package rv32i_gcd_pkg SHALL hold the state enum, GCD_RESULT_REG=10, GCD_A_REG=28, GCD_B_REG=29, GCD_START_REG=31 and LAUNCH_CYCLES=2.
REQ-022 The timeout counter SHALL be sub-module rv32i_gcd_timeout_cnt (inputs clear, enable; output expired).
REQ-023 SHALL contain no combinational path from req_* or wb_* inputs to any output.

Verification
REQ-024 a=48, b=18; stub core writes x10=6 20 cycles into RUN -> core_rst_n low 2 cycles, calc_start=1 from T+3, resp_result=6, timeout=0 one cycle after the write.
REQ-025 a=0, b=35 -> RESP at T+1, result=35, core_rst_n never low, calc_start never high.
REQ-026 TIMEOUT_CYCLES=16, no x10 write -> RESP after 16 RUN cycles, result=0, timeout=1.
REQ-027 TIMEOUT_CYCLES=16, x10=7 written in cycle 15 of RUN -> result=7, timeout=0.
REQ-028 resp_ready held low 10 cycles, with x10 writes of 9 during RESP -> outputs stable at the original result; req_ready=0 until the cycle after the handshake.
REQ-029 rst_n asserted mid-RUN -> all outputs at reset values immediately; no resp_valid; next request a=21, b=14 with x10=7 completes normally.
